// File: rtl/nx1_varb.sv
// nx1_varb: arbitrates one single-port synchronous VRAM between the Z80 and the display fetch.
// Optional: define NX1_VARB_FAIR_EN so a CPU starved by a display grant wins the next contest.
module nx1_varb #(
   parameter int MEM_LAT = 1
) (
   input  logic        I_CLK,
   input  logic        I_RESET_n,
   input  logic        I_CPU_REQ,
   input  logic        I_CPU_WE,
   input  logic [15:0] I_CPU_A,
   input  logic [7:0]  I_CPU_DO,
   output logic [7:0]  O_CPU_DI,
   output logic        O_CPU_WAIT_n,
   input  logic        I_DISP_REQ,
   input  logic [15:0] I_DISP_A,
   output logic [7:0]  O_DISP_D,
   output logic        O_DISP_VALID,
   output logic        O_DISP_OVR,
   input  logic        I_DISP_OVR_CLR,
   output logic        O_MEM_EN,
   output logic        O_MEM_WE,
   output logic [15:0] O_MEM_A,
   output logic [7:0]  O_MEM_DO,
   input  logic [7:0]  I_MEM_DI
);

   typedef enum logic [1:0] {IDLE, ISSUE, LAT, DONE} state_t;

   localparam logic [1:0] LAT_LAST = 2'((MEM_LAT > 1) ? (MEM_LAT - 2) : 0);

   state_t      state_q, state_d;
   logic [1:0]  lat_cnt_q, lat_cnt_d;

   logic        req_prev_q;
   logic        cpu_pend_q, cpu_pend_d;
   logic        cpu_live_q, cpu_live_d;
   logic        cpu_done_q, cpu_done_d;
   logic        disp_pend_q, disp_pend_d;
   logic [15:0] disp_a_q, disp_a_d;
   logic        disp_ovr_q, disp_ovr_d;
   logic        gnt_disp_q, gnt_disp_d;
   logic        gnt_we_q, gnt_we_d;
   logic [15:0] mem_a_q, mem_a_d;
   logic [7:0]  mem_do_q, mem_do_d;
   logic [7:0]  cpu_di_q, cpu_di_d;
   logic [7:0]  disp_d_q, disp_d_d;

   logic        cpu_first;
   logic        grant_disp;
   logic        grant_cpu;
   logic        in_done;

`ifdef NX1_VARB_FAIR_EN
   logic        tok_q, tok_d;

   always_comb begin
      cpu_first = tok_q & cpu_pend_q;
      tok_d     = tok_q;
      if (grant_disp && cpu_pend_q) tok_d = 1'b1;
      if (grant_cpu)                tok_d = 1'b0;
   end

   always_ff @(posedge I_CLK or negedge I_RESET_n) begin
      if (!I_RESET_n) tok_q <= 1'b0;
      else            tok_q <= tok_d;
   end
`else
   always_comb begin
      cpu_first = 1'b0;
   end
`endif

   // Grants are only issued from IDLE, so one access is ever in flight.
   always_comb begin
      grant_disp = 1'b0;
      grant_cpu  = 1'b0;
      in_done    = (state_q == DONE);
      if (state_q == IDLE) begin
         if (disp_pend_q && !cpu_first) grant_disp = 1'b1;
         else if (cpu_pend_q)           grant_cpu  = 1'b1;
      end
   end

   always_ff @(posedge I_CLK or negedge I_RESET_n) begin
      if (!I_RESET_n) begin
         state_q   <= IDLE;
         lat_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         lat_cnt_q <= lat_cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      lat_cnt_d = lat_cnt_q;
      case (state_q)
         IDLE: begin
            if (grant_disp || grant_cpu) state_d = ISSUE;
         end
         ISSUE: begin
            lat_cnt_d = '0;
            if (MEM_LAT > 1) state_d = LAT;
            else             state_d = DONE;
         end
         LAT: begin
            if (lat_cnt_q == LAT_LAST) state_d = DONE;
            else                       lat_cnt_d = lat_cnt_q + 2'd1;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // cpu_live drops if the CPU lets go mid-access, so a stale completion never releases WAIT.
   always_comb begin
      cpu_pend_d = cpu_pend_q;
      if (grant_cpu)                    cpu_pend_d = 1'b0;
      if (I_CPU_REQ && !req_prev_q)     cpu_pend_d = 1'b1;
      cpu_live_d = grant_cpu ? I_CPU_REQ : (cpu_live_q & I_CPU_REQ);
      cpu_done_d = I_CPU_REQ & (cpu_done_q | (in_done & ~gnt_disp_q & cpu_live_q));

      disp_pend_d = disp_pend_q;
      disp_a_d    = disp_a_q;
      if (grant_disp) disp_pend_d = 1'b0;
      if (I_DISP_REQ) begin
         disp_pend_d = 1'b1;
         disp_a_d    = I_DISP_A;
      end
      disp_ovr_d = disp_ovr_q;
      if (I_DISP_OVR_CLR)                             disp_ovr_d = 1'b0;
      if (I_DISP_REQ && disp_pend_q && !grant_disp)   disp_ovr_d = 1'b1;

      gnt_disp_d = gnt_disp_q;
      gnt_we_d   = gnt_we_q;
      mem_a_d    = mem_a_q;
      mem_do_d   = mem_do_q;
      if (grant_disp) begin
         gnt_disp_d = 1'b1;
         gnt_we_d   = 1'b0;
         mem_a_d    = disp_a_q;
      end else if (grant_cpu) begin
         gnt_disp_d = 1'b0;
         gnt_we_d   = I_CPU_WE;
         mem_a_d    = I_CPU_A;
         mem_do_d   = I_CPU_DO;
      end

      cpu_di_d  = cpu_di_q;
      disp_d_d  = disp_d_q;
      if (in_done) begin
         if (gnt_disp_q)     disp_d_d = I_MEM_DI;
         else if (!gnt_we_q) cpu_di_d = I_MEM_DI;
      end
   end

   always_ff @(posedge I_CLK or negedge I_RESET_n) begin
      if (!I_RESET_n) begin
         req_prev_q  <= 1'b0;
         cpu_pend_q  <= 1'b0;
         cpu_live_q  <= 1'b0;
         cpu_done_q  <= 1'b0;
         disp_pend_q <= 1'b0;
         disp_a_q    <= '0;
         disp_ovr_q  <= 1'b0;
         gnt_disp_q  <= 1'b0;
         gnt_we_q    <= 1'b0;
         mem_a_q     <= '0;
         mem_do_q    <= '0;
         cpu_di_q    <= '0;
         disp_d_q    <= '0;
      end else begin
         req_prev_q  <= I_CPU_REQ;
         cpu_pend_q  <= cpu_pend_d;
         cpu_live_q  <= cpu_live_d;
         cpu_done_q  <= cpu_done_d;
         disp_pend_q <= disp_pend_d;
         disp_a_q    <= disp_a_d;
         disp_ovr_q  <= disp_ovr_d;
         gnt_disp_q  <= gnt_disp_d;
         gnt_we_q    <= gnt_we_d;
         mem_a_q     <= mem_a_d;
         mem_do_q    <= mem_do_d;
         cpu_di_q    <= cpu_di_d;
         disp_d_q    <= disp_d_d;
      end
   end

   // Display data is passed straight through during DONE so it is valid with the strobe.
   always_comb begin
      O_MEM_EN     = (state_q == ISSUE);
      O_MEM_WE     = (state_q == ISSUE) & gnt_we_q;
      O_MEM_A      = mem_a_q;
      O_MEM_DO     = mem_do_q;
      O_CPU_DI     = cpu_di_q;
      O_CPU_WAIT_n = ~(I_CPU_REQ & ~cpu_done_q);
      O_DISP_VALID = in_done & gnt_disp_q;
      O_DISP_D     = (in_done && gnt_disp_q) ? I_MEM_DI : disp_d_q;
      O_DISP_OVR   = disp_ovr_q;
   end

endmodule

// File: tb/tb_nx1_varb.sv
// Directed bench for nx1_varb: instance u0 uses MEM_LAT=1, instance u1 uses MEM_LAT=2.
module tb_nx1_varb;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        cpu_req0, cpu_we0, wait_n0, disp_req0, disp_valid0, disp_ovr0, ovr_clr0;
   logic        mem_en0, mem_we0;
   logic [15:0] cpu_a0, disp_a0, mem_a0;
   logic [7:0]  cpu_do0, cpu_di0, disp_d0, mem_do0, rd0;
   logic        cpu_req1, cpu_we1, wait_n1, disp_req1, disp_valid1, disp_ovr1, ovr_clr1;
   logic        mem_en1, mem_we1;
   logic [15:0] cpu_a1, disp_a1, mem_a1;
   logic [7:0]  cpu_do1, cpu_di1, disp_d1, mem_do1, rd1a, rd1b;

   int          checks = 0;
   int          passed = 0;
   int          vcnt0 = 0;
   int          vcnt1 = 0;
   int          vsnap;

   nx1_varb #(.MEM_LAT(1)) u0 (
      .I_CLK(clk), .I_RESET_n(rst_n),
      .I_CPU_REQ(cpu_req0), .I_CPU_WE(cpu_we0), .I_CPU_A(cpu_a0), .I_CPU_DO(cpu_do0),
      .O_CPU_DI(cpu_di0), .O_CPU_WAIT_n(wait_n0),
      .I_DISP_REQ(disp_req0), .I_DISP_A(disp_a0), .O_DISP_D(disp_d0),
      .O_DISP_VALID(disp_valid0), .O_DISP_OVR(disp_ovr0), .I_DISP_OVR_CLR(ovr_clr0),
      .O_MEM_EN(mem_en0), .O_MEM_WE(mem_we0), .O_MEM_A(mem_a0), .O_MEM_DO(mem_do0),
      .I_MEM_DI(rd0)
   );

   nx1_varb #(.MEM_LAT(2)) u1 (
      .I_CLK(clk), .I_RESET_n(rst_n),
      .I_CPU_REQ(cpu_req1), .I_CPU_WE(cpu_we1), .I_CPU_A(cpu_a1), .I_CPU_DO(cpu_do1),
      .O_CPU_DI(cpu_di1), .O_CPU_WAIT_n(wait_n1),
      .I_DISP_REQ(disp_req1), .I_DISP_A(disp_a1), .O_DISP_D(disp_d1),
      .O_DISP_VALID(disp_valid1), .O_DISP_OVR(disp_ovr1), .I_DISP_OVR_CLR(ovr_clr1),
      .O_MEM_EN(mem_en1), .O_MEM_WE(mem_we1), .O_MEM_A(mem_a1), .O_MEM_DO(mem_do1),
      .I_MEM_DI(rd1b)
   );

   // VRAM contents are a fixed function of the address; write cycles return EE.
   function automatic logic [7:0] vram(input logic [15:0] a);
      return a[7:0] ^ a[15:8] ^ 8'h90;
   endfunction

   always @(posedge clk) begin
      if (mem_en0) rd0 <= mem_we0 ? 8'hEE : vram(mem_a0);
      if (mem_en1) rd1a <= mem_we1 ? 8'hEE : vram(mem_a1);
      rd1b <= rd1a;
      if (disp_valid0) vcnt0 <= vcnt0 + 1;
      if (disp_valid1) vcnt1 <= vcnt1 + 1;
   end

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
   endtask

   task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; rd0 = '0; rd1a = '0; rd1b = '0;
      cpu_req0 = 0; cpu_we0 = 0; cpu_a0 = '0; cpu_do0 = '0; disp_req0 = 0; disp_a0 = '0; ovr_clr0 = 0;
      cpu_req1 = 0; cpu_we1 = 0; cpu_a1 = '0; cpu_do1 = '0; disp_req1 = 0; disp_a1 = '0; ovr_clr1 = 0;
      repeat (3) cyc();
      chk1("rst_en", mem_en0, 1'b0);
      chk16("rst_a", mem_a0, 16'h0000);
      chk8("rst_cpu_di", cpu_di0, 8'h00);
      chk1("rst_valid", disp_valid0, 1'b0);
      chk1("rst_ovr", disp_ovr0, 1'b0);
      chk1("rst_wait_idle", wait_n0, 1'b1);
      cpu_req0 = 1; #1;
      chk1("rst_wait_req", wait_n0, 1'b0);
      cpu_req0 = 0;
      rst_n = 1'b1;
      cyc(); cyc();

      // CPU read, MEM_LAT=1
      cpu_a0 = 16'h3005; cpu_we0 = 0; cpu_do0 = 8'h11; cpu_req0 = 1; #1;
      chk1("A_wait_same", wait_n0, 1'b0);
      cyc(); chk1("A_idle_en", mem_en0, 1'b0);
      cyc();
      chk1("A_issue_en", mem_en0, 1'b1);
      chk16("A_issue_a", mem_a0, 16'h3005);
      chk1("A_issue_we", mem_we0, 1'b0);
      chk8("A_issue_do", mem_do0, 8'h11);
      cyc();
      chk1("A_done_en", mem_en0, 1'b0);
      chk1("A_done_wait", wait_n0, 1'b0);
      cyc();
      chk8("A_cpu_di", cpu_di0, 8'hA5);
      chk1("A_wait_rel", wait_n0, 1'b1);
      cpu_req0 = 0; cyc(); cyc();

      // CPU and display arrive together; a second display strobe arrives mid-access
      vsnap = vcnt0;
      cpu_a0 = 16'h1234; cpu_req0 = 1; disp_a0 = 16'h0400; disp_req0 = 1;
      cyc(); disp_req0 = 0;
      cyc();
      chk1("B_issue1_en", mem_en0, 1'b1);
      chk16("B_issue1_a", mem_a0, 16'h0400);
      disp_a0 = 16'h0500; disp_req0 = 1;
      cyc(); disp_req0 = 0;
      chk1("B_valid1", disp_valid0, 1'b1);
      chk8("B_disp_d1", disp_d0, 8'h94);
      cyc();
      chk1("B_valid1_end", disp_valid0, 1'b0);
      chk8("B_disp_d1_hold", disp_d0, 8'h94);
      cyc();
      chk1("B_issue2_en", mem_en0, 1'b1);
`ifdef NX1_VARB_FAIR_EN
      chk16("B_issue2_a_fair", mem_a0, 16'h1234);
`else
      chk16("B_issue2_a_strict", mem_a0, 16'h0500);
`endif
      for (int i = 0; i < 20 && wait_n0 === 1'b0; i++) cyc();
      chk1("B_wait_rel", wait_n0, 1'b1);
      chk8("B_cpu_di", cpu_di0, 8'hB6);
      cpu_req0 = 0;
      repeat (5) cyc();
      chk16("B_valid_count", 16'(vcnt0 - vsnap), 16'd2);
      chk8("B_disp_d2", disp_d0, 8'h95);
      chk1("B_no_ovr", disp_ovr0, 1'b0);

      // Two display strobes while the CPU holds the port: overrun, only the second is fetched
      vsnap = vcnt0;
      cpu_a0 = 16'h4000; cpu_req0 = 1;
      cyc(); cyc();
      chk16("C_cpu_issue_a", mem_a0, 16'h4000);
      disp_a0 = 16'h0600; disp_req0 = 1;
      cyc();
      disp_a0 = 16'h0700; ovr_clr0 = 1;
      cyc();
      disp_req0 = 0; ovr_clr0 = 0;
      chk1("C_ovr_set_wins", disp_ovr0, 1'b1);
      chk1("C_cpu_wait_rel", wait_n0, 1'b1);
      chk8("C_cpu_di", cpu_di0, 8'hD0);
      cyc();
      chk1("C_disp_issue_en", mem_en0, 1'b1);
      chk16("C_disp_issue_a", mem_a0, 16'h0700);
      cyc();
      chk1("C_valid", disp_valid0, 1'b1);
      chk8("C_disp_d", disp_d0, 8'h97);
      cyc(); cyc();
      chk16("C_valid_count", 16'(vcnt0 - vsnap), 16'd1);
      chk1("C_ovr_sticky", disp_ovr0, 1'b1);
      ovr_clr0 = 1; cyc(); ovr_clr0 = 0;
      chk1("C_ovr_clr", disp_ovr0, 1'b0);
      cpu_req0 = 0; cyc();

      // MEM_LAT=2: read to load CPU_DI, then a write must leave it alone
      cpu_a1 = 16'h3005; cpu_we1 = 0; cpu_req1 = 1;
      cyc();
      for (int i = 0; i < 20 && wait_n1 === 1'b0; i++) cyc();
      chk8("D_read_di", cpu_di1, 8'hA5);
      cpu_req1 = 0; cyc(); cyc();
      cpu_a1 = 16'h2000; cpu_do1 = 8'h5A; cpu_we1 = 1; cpu_req1 = 1; #1;
      chk1("D_wait_same", wait_n1, 1'b0);
      cyc(); cyc();
      chk1("D_issue_en", mem_en1, 1'b1);
      chk1("D_issue_we", mem_we1, 1'b1);
      chk16("D_issue_a", mem_a1, 16'h2000);
      chk8("D_issue_do", mem_do1, 8'h5A);
      cyc();
      chk1("D_lat_we", mem_we1, 1'b0);
      chk1("D_lat_wait", wait_n1, 1'b0);
      cyc();
      chk1("D_done_wait", wait_n1, 1'b0);
      cyc();
      chk1("D_wait_rel", wait_n1, 1'b1);
      chk8("D_di_unchanged", cpu_di1, 8'hA5);
      cpu_req1 = 0; cpu_we1 = 0; cyc(); cyc();

      // Reset during LAT of a display access on the MEM_LAT=2 instance
      vsnap = vcnt1;
      disp_a1 = 16'h0900; disp_req1 = 1;
      cyc(); disp_req1 = 0;
      cyc();
      chk16("E_issue_a", mem_a1, 16'h0900);
      cyc();
      rst_n = 1'b0; #1;
      chk1("E_rst_en", mem_en1, 1'b0);
      chk1("E_rst_valid", disp_valid1, 1'b0);
      chk16("E_rst_a", mem_a1, 16'h0000);
      chk8("E_rst_cpu_di", cpu_di1, 8'h00);
      chk8("E_rst_disp_d", disp_d1, 8'h00);
      cyc(); cyc();
      rst_n = 1'b1;
      cyc(); cyc();
      chk16("E_no_valid", 16'(vcnt1 - vsnap), 16'd0);
      cpu_a1 = 16'h3005; cpu_req1 = 1;
      cyc();
      for (int i = 0; i < 20 && wait_n1 === 1'b0; i++) cyc();
      chk1("E_post_wait_rel", wait_n1, 1'b1);
      chk8("E_post_di", cpu_di1, 8'hA5);
      cpu_req1 = 0; cyc();

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/nx1_varb.md
NX1_VARB -- requirements
Module: nx1_varb

Interface
REQ-001 SHALL have parameter: MEM_LAT, 1, VRAM read latency in clocks from O_MEM_EN to I_MEM_DI valid (legal 1..2).
REQ-002 SHALL have ports: I_CLK  in  1  single clock, all logic on rising edge.
REQ-003 SHALL have ports: I_RESET_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have ports: I_CPU_REQ in 1 level, VRAM chip-select from the address decoder qualified by RD or WR; I_CPU_WE in 1 write when high; I_CPU_A in 16; I_CPU_DO in 8 write data.
REQ-005 SHALL have ports: O_CPU_DI out 8 read data; O_CPU_WAIT_n out 1 Z80 wait.
REQ-006 SHALL have ports: I_DISP_REQ in 1 one-clock fetch strobe; I_DISP_A in 16; O_DISP_D out 8; O_DISP_VALID out 1; O_DISP_OVR out 1 sticky overrun; I_DISP_OVR_CLR in 1.
REQ-007 SHALL have ports: O_MEM_EN out 1; O_MEM_WE out 1; O_MEM_A out 16; O_MEM_DO out 8; I_MEM_DI in 8 (single-port synchronous VRAM).

Function
REQ-008 SHALL arbitrate the single VRAM port between CPU and display fetch; one access in flight at a time.
REQ-009 SHALL implement states IDLE, ISSUE, LAT, DONE; ISSUE drives O_MEM_EN=1 for exactly one clock with the granted address/WE/data; LAT lasts MEM_LAT-1 clocks (skipped when MEM_LAT=1); DONE captures I_MEM_DI and returns to IDLE; each access occupies MEM_LAT+1 clocks plus one IDLE clock.
REQ-010 SHALL set cpu_pend on the rising edge of I_CPU_REQ (registered previous value) and clear it on grant.
REQ-011 SHALL drive O_CPU_WAIT_n combinationally low whenever I_CPU_REQ=1 and cpu_done=0, so WAIT is asserted in the same clock the request appears.
REQ-012 SHALL set cpu_done in DONE of a CPU access and clear it when I_CPU_REQ falls; a CPU read SHALL load O_CPU_DI in DONE and hold it until the next CPU read completes; writes SHALL not alter O_CPU_DI.
REQ-013 SHALL hold a one-deep display pending register set by I_DISP_REQ with I_DISP_A latched; a strobe while pending and not yet granted SHALL overwrite the address and set O_DISP_OVR.
REQ-014 SHALL pulse O_DISP_VALID for one clock in DONE of a display access with O_DISP_D valid that clock and held afterwards.
REQ-015 SHALL, in IDLE with both pending, grant display first (strict priority, see REQ-021).
REQ-016 SHALL accept I_DISP_REQ in the same clock a display grant occurs as a new pending request (no overrun).
REQ-017 SHALL clear O_DISP_OVR on I_DISP_OVR_CLR; a simultaneous set SHALL win.
REQ-018 SHALL complete a started CPU access even if I_CPU_REQ falls mid-access; cpu_done then stays 0.

Reset
REQ-019 SHALL, on I_RESET_n low, immediately force state IDLE, clear cpu_pend, cpu_done, display pending, fairness token, O_MEM_EN=0, O_MEM_WE=0, O_MEM_A=0, O_MEM_DO=0, O_CPU_DI=0, O_DISP_D=0, O_DISP_VALID=0, O_DISP_OVR=0; O_CPU_WAIT_n follows REQ-011 with cpu_done=0.
REQ-020 SHALL abandon any in-flight access on reset with no O_DISP_VALID or cpu_done produced.

Configuration
REQ-021 SHALL, with macro NX1_VARB_FAIR_EN defined, keep a token set whenever a display grant occurs while cpu_pend=1, give CPU priority over a pending display when the token is set, and clear the token on CPU grant; without the macro, display priority is strict and no token exists.

Verification
REQ-022 SHALL cover: MEM_LAT=1, CPU read A=16'h3005, VRAM holds 8'hA5 -> WAIT_n low same clock, O_MEM_EN one clock with A=3005, O_CPU_DI=A5 and WAIT_n high 2 clocks after ISSUE.
REQ-023 SHALL cover: CPU_REQ and DISP_REQ rise same clock -> display access first, CPU access next; with NX1_VARB_FAIR_EN and a second DISP_REQ during first access -> CPU before second display.
REQ-024 SHALL cover: two DISP_REQ strobes 1 clock apart while CPU access busy -> O_DISP_OVR=1, only second address fetched, one O_DISP_VALID; I_DISP_OVR_CLR -> OVR=0.
REQ-025 SHALL cover: MEM_LAT=2, CPU write A=16'h2000 D=8'h5A -> O_MEM_WE=1 one clock, WAIT_n released 3 clocks after ISSUE, O_CPU_DI unchanged.
REQ-026 SHALL cover: I_RESET_n low during LAT of a display access -> no O_DISP_VALID, all outputs at reset values, first post-reset CPU request served normally.
